mem_port_arbiter: RTL and testbench

// - Shares the single-port data/instruction memory between two requesters: port 0 = instruction fetch, port 1 = load/store unit.
// - Arbitrates, registers the winning request, drives one memory access, returns read data with rvalid; stalls the loser via gnt.
// - Sits between the core's fetch/LSU stages and the memory model (wen/a/d/q interface).

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/arb_pick.sv | 27 ++
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter.
// Contents: arbiter FSM state type, port indices, port count and a helper
// that turns a port index into a one-hot vector.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam int NUM_PORTS = 2;
  localparam int PORT_IF   = 0;  // instruction fetch
  localparam int PORT_LSU  = 1;  // load/store unit

  function automatic logic [NUM_PORTS-1:0] port_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection for the two-port memory arbiter.
// Ports:
//   en_i    - grants allowed this cycle (FSM in IDLE or RESP)
//   req_i   - per-port request
//   prio0_i - port 0 wins a tie (starvation guard or round-robin pointer)
//   gnt_o   - one-hot grant, zero when disabled or nothing requested
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic                 en_i,
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic                 prio0_i,
  output logic [NUM_PORTS-1:0] gnt_o
);

  always_comb begin
    gnt_o = '0;
    if (en_i) begin
      if (req_i[PORT_IF] && (!req_i[PORT_LSU] || prio0_i)) begin
        gnt_o[PORT_IF] = 1'b1;
      end else if (req_i[PORT_LSU]) begin
        gnt_o[PORT_LSU] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch (port 0) and the
// load/store unit (port 1). A request is granted combinationally, the memory
// is accessed in the following cycle and the response (rvalid/rdata) comes
// one cycle after that. Writes are acknowledged with rdata = 0.
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset
//   req_i, we_i        - per-port request / write enable
//   addr0_i, addr1_i   - per-port byte address
//   wdata1_i           - port 1 write data (port 0 writes store 0)
//   gnt_o              - one-hot grant pulse (combinational)
//   rvalid_o, rdata_o  - one-hot response valid and response data
//   mem_wen/a/d, mem_q - memory interface (combinational read data)
// Configuration:
//   ARB_ROUND_ROBIN_EN - ties go to a round-robin pointer instead of
//                        fixed port-1 priority with the MAX_WAIT guard.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int BITS     = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [NUM_PORTS-1:0] we_i,
  input  logic [BITS-1:0]      addr0_i,
  input  logic [BITS-1:0]      addr1_i,
  input  logic [BITS-1:0]      wdata1_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic [NUM_PORTS-1:0] rvalid_o,
  output logic [BITS-1:0]      rdata_o,
  output logic                 mem_wen,
  output logic [BITS-1:0]      mem_a,
  output logic [BITS-1:0]      mem_d,
  input  logic [BITS-1:0]      mem_q
);

  state_e                 state_q, state_d;
  logic                   owner_q;
  logic                   we_q;
  logic [BITS-1:0]        addr_q;
  logic [BITS-1:0]        wdata_q;
  logic [BITS-1:0]        rdata_q;
  logic                   grant_en;
  logic                   prio0;
  logic                   win;
  logic [NUM_PORTS-1:0]   gnt;

`ifdef ARB_ROUND_ROBIN_EN
  // Pointer names the port that wins the next tie; it flips away from
  // whichever port was just granted.
  logic rr_ptr_q;

  assign prio0 = ~rr_ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= 1'b1;
    end else if (|gnt) begin
      rr_ptr_q <= ~win;
    end
  end
`else
  // Counts port-1 grants taken while port 0 is waiting; at MAX_WAIT port 0
  // is forced through. A width of at least 1 keeps MAX_WAIT=0 legal, where
  // the counter sits at 0 == MAX_WAIT and port 0 always wins ties.
  localparam int SW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  logic [SW-1:0] starve_q, starve_d;

  assign prio0 = (starve_q == SW'(MAX_WAIT));

  always_comb begin
    starve_d = starve_q;
    if (!req_i[PORT_IF] || gnt[PORT_IF]) begin
      starve_d = '0;
    end else if (gnt[PORT_LSU] && (starve_q != SW'(MAX_WAIT))) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`endif

  // New grants only when the memory slot for the next cycle is free.
  assign grant_en = (state_q == IDLE) || (state_q == RESP);

  arb_pick u_pick (
    .en_i    (grant_en),
    .req_i   (req_i),
    .prio0_i (prio0),
    .gnt_o   (gnt)
  );

  assign win = gnt[PORT_LSU];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|gnt) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = (|gnt) ? ACCESS : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (|gnt) begin
        owner_q <= win;
        we_q    <= we_i[win];
        addr_q  <= win ? addr1_i : addr0_i;
        wdata_q <= win ? wdata1_i : '0;
      end
      if (state_q == ACCESS) begin
        rdata_q <= we_q ? '0 : mem_q;
      end
    end
  end

  assign gnt_o    = gnt;
  assign rvalid_o = (state_q == RESP) ? port_onehot(owner_q) : '0;
  assign rdata_o  = (state_q == RESP) ? rdata_q : '0;
  // Address/data simply hold the last latched request; only wen is gated.
  assign mem_wen  = (state_q == ACCESS) && we_q;
  assign mem_a    = addr_q;
  assign mem_d    = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a word memory model and a
// response scoreboard. Build with ARB_ROUND_ROBIN_EN to check the
// round-robin tie pattern instead of the fixed-priority one.
module tb_mem_port_arbiter;

  localparam int BITS = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      req_i, we_i;
  logic [BITS-1:0] addr0_i, addr1_i, wdata1_i;
  logic [1:0]      gnt_o, rvalid_o;
  logic [BITS-1:0] rdata_o;
  logic            mem_wen;
  logic [BITS-1:0] mem_a, mem_d, mem_q;

  always #5 clk = ~clk;

  mem_port_arbiter #(.BITS(BITS), .MAX_WAIT(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (req_i),
    .we_i     (we_i),
    .addr0_i  (addr0_i),
    .addr1_i  (addr1_i),
    .wdata1_i (wdata1_i),
    .gnt_o    (gnt_o),
    .rvalid_o (rvalid_o),
    .rdata_o  (rdata_o),
    .mem_wen  (mem_wen),
    .mem_a    (mem_a),
    .mem_d    (mem_d),
    .mem_q    (mem_q)
  );

  // Memory model: 64 words, byte address bits [7:2].
  logic [31:0] mem     [0:63];
  logic [31:0] exp_mem [0:63];

  assign mem_q = mem[mem_a[7:2]];

  always @(posedge clk) begin
    if (mem_wen) mem[mem_a[7:2]] <= mem_d;
  end

  typedef struct packed {
    logic [1:0]  port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } sb_t;

  sb_t sb[$];

  int checks   = 0;
  int failures = 0;

  logic [1:0]  o_gnt, o_rvalid;
  logic        o_wen;
  logic [31:0] o_a, o_d, o_rdata;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample at the falling edge, retire responses against
  // the scoreboard, enqueue newly granted requests, return at posedge+1.
  task automatic tick();
    sb_t e;
    logic w;
    @(negedge clk);
    o_gnt    = gnt_o;
    o_rvalid = rvalid_o;
    o_rdata  = rdata_o;
    o_wen    = mem_wen;
    o_a      = mem_a;
    o_d      = mem_d;
    if (rvalid_o != 2'b00) begin
      if (sb.size() == 0) begin
        chk("unexpected_rvalid", rvalid_o, 2'b00);
      end else begin
        e = sb.pop_front();
        chk("sb_port", rvalid_o, e.port);
        if (e.we) begin
          chk("sb_write_rdata", rdata_o, 32'h0);
          exp_mem[e.addr[7:2]] = e.data;
        end else begin
          chk("sb_read_rdata", rdata_o, exp_mem[e.addr[7:2]]);
        end
      end
    end
    if (gnt_o != 2'b00) begin
      w      = gnt_o[1];
      e.port = gnt_o;
      e.we   = we_i[w];
      e.addr = w ? addr1_i : addr0_i;
      e.data = w ? wdata1_i : 32'h0;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
  endtask

  initial begin
    logic [1:0] expg;
    rst_n    = 1'b0;
    req_i    = 2'b00;
    we_i     = 2'b00;
    addr0_i  = '0;
    addr1_i  = '0;
    wdata1_i = '0;
    for (int i = 0; i < 64; i++) begin
      mem[i]     = 32'h0;
      exp_mem[i] = 32'h0;
    end
    mem[4]     = 32'hDEADBEEF;
    exp_mem[4] = 32'hDEADBEEF;
    mem[3]     = 32'h12345678;
    exp_mem[3] = 32'h12345678;

    // Reset state and idle behaviour
    #12;
    chk("reset_outs", {gnt_o, rvalid_o, rdata_o, mem_wen, mem_a, mem_d}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_outs", {o_gnt, o_rvalid, o_rdata, o_wen, o_a, o_d}, '0);
    end

    // Port 0 read of 0x10
    req_i   = 2'b01;
    we_i    = 2'b00;
    addr0_i = 32'h10;
    tick();
    chk("p0_gnt", o_gnt, 2'b01);
    req_i = 2'b00;
    tick();
    chk("p0_mem_a", o_a, 32'h10);
    chk("p0_wen", o_wen, 1'b0);
    chk("p0_gnt_access", o_gnt, 2'b00);
    tick();
    chk("p0_rvalid", o_rvalid, 2'b01);
    chk("p0_rdata", o_rdata, 32'hDEADBEEF);

    // Port 1 write 0x55 to 0x08, then read it back
    req_i    = 2'b10;
    we_i     = 2'b10;
    addr1_i  = 32'h08;
    wdata1_i = 32'h55;
    tick();
    chk("p1w_gnt", o_gnt, 2'b10);
    req_i = 2'b00;
    we_i  = 2'b00;
    tick();
    chk("p1w_mem", {o_wen, o_a, o_d}, {1'b1, 32'h08, 32'h55});
    tick();
    chk("p1w_wen_low", o_wen, 1'b0);
    chk("p1w_rvalid", o_rvalid, 2'b10);
    chk("p1w_rdata", o_rdata, 32'h0);
    req_i = 2'b10;
    tick();
    chk("p1r_gnt", o_gnt, 2'b10);
    req_i = 2'b00;
    tick();
    tick();
    chk("p1r_rvalid", o_rvalid, 2'b10);
    chk("p1r_rdata", o_rdata, 32'h55);

    // Both ports requesting continuously
    do_reset();
    req_i   = 2'b11;
    we_i    = 2'b00;
    addr0_i = 32'h10;
    addr1_i = 32'h08;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i % 2 == 0) begin
`ifdef ARB_ROUND_ROBIN_EN
        expg = ((i / 2) % 2 == 0) ? 2'b10 : 2'b01;
`else
        expg = ((i / 2) % 5 == 4) ? 2'b01 : 2'b10;
`endif
      end else begin
        expg = 2'b00;
      end
      chk("tie_gnt", o_gnt, expg);
    end
    req_i = 2'b00;
    tick();
    tick();
    chk("tie_drained", sb.size(), 0);

    // Reset asserted during the ACCESS cycle of a write
    req_i    = 2'b10;
    we_i     = 2'b10;
    addr1_i  = 32'h0C;
    wdata1_i = 32'hA5A5A5A5;
    tick();
    chk("rst_gnt", o_gnt, 2'b10);
    req_i = 2'b00;
    we_i  = 2'b00;
    #2;
    chk("rst_pre_wen", mem_wen, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_wen_drop", mem_wen, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_no_rvalid", o_rvalid, 2'b00);
    end
    chk("rst_mem_kept", mem[3], 32'h12345678);
    req_i   = 2'b01;
    addr0_i = 32'h0C;
    tick();
    req_i = 2'b00;
    tick();
    tick();
    chk("rst_readback_rvalid", o_rvalid, 2'b01);
    chk("rst_readback_rdata", o_rdata, 32'h12345678);
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
